axil_slave_regs: RTL and testbench
==================================

Name: axil_slave_regs

Overview:
- AXI4-Lite responder: bank of NUM_REGS memory-mapped 32-bit registers attached to one master port (m1/m2) of the bus interconnect.
- Accepts write address/data independently, returns a write response, serves reads with registered data.
- Decodes out-of-range accesses to SLVERR.

Parameters:
- DATA_WIDTH, 32, data bus width; must be 32 in this block.
- ADDR_WIDTH, 8, byte address width.
- RESP_WIDTH, 3, response field width, matching the bus.
- NUM_REGS, 16, number of word registers; must be at most 2^(ADDR_WIDTH-2).
- ID_VALUE, 32'hA5A5_0001, constant for the optional ID register.

Ports:
- s_axi_aclk  in  1  clock; all logic is on the rising edge.
- s_axi_areset  in  1  asynchronous, active-high reset.
- s_axi_awaddr  in  ADDR_WIDTH  write byte address.
- s_axi_awvalid  in  1  / s_axi_awready  out  1  write address handshake.
- s_axi_wdata  in  DATA_WIDTH  write data.
- s_axi_wstrb  in  DATA_WIDTH/8  byte enables.
- s_axi_wvalid  in  1  / s_axi_wready  out  1  write data handshake.
- s_axi_bresp  out  RESP_WIDTH  write response.
- s_axi_bvalid  out  1  / s_axi_bready  in  1  write response handshake.
- s_axi_araddr  in  ADDR_WIDTH  read byte address.
- s_axi_arvalid  in  1  / s_axi_arready  out  1  read address handshake.
- s_axi_rdata  out  DATA_WIDTH  read data.
- s_axi_rresp  out  RESP_WIDTH  read response.
- s_axi_rvalid  out  1  / s_axi_rready  in  1  read data handshake.

Behaviour:
- Reset (asynchronous, active-high; takes effect immediately, including mid-transaction):
  - All registers clear to 0.
  - awready=1, wready=1, arready=1.
  - bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0.
  - Both FSMs return to IDLE and all latched addresses/data are discarded.
- Decode:
  - Register index = addr[ADDR_WIDTH-1:2]; addr[1:0] are ignored.
  - Index < NUM_REGS gives OKAY (0); index >= NUM_REGS gives SLVERR (2).
  - Responses are zero-extended to RESP_WIDTH.
- Write FSM, states W_IDLE, W_RESP:
  - In W_IDLE, awready=1 until an AW handshake is latched, then 0.
  - In W_IDLE, wready=1 until a W handshake is latched, then 0.
  - AW and W may arrive in the same cycle or in either order, any number of cycles apart.
  - On the edge where the second of AW/W is captured (or both together), the write commits: byte lane i updates only if wstrb[i]=1.
  - On that same edge: bresp is set, bvalid goes to 1, state moves to W_RESP.
  - Latency: bvalid is high 1 cycle after the completing handshake.
  - In W_RESP: awready=wready=0; bvalid and bresp hold until bready=1.
  - On B handshake: return to W_IDLE with awready=wready=1 on the next cycle.
  - SLVERR writes modify nothing.
  - wstrb=0 to a valid index: no change, OKAY.
- Read FSM, states R_IDLE, R_DATA:
  - In R_IDLE, arready=1.
  - On AR handshake: rdata and rresp are registered, rvalid=1, state moves to R_DATA, arready=0.
  - Latency: 1 cycle.
  - SLVERR reads return rdata=0.
  - rvalid, rdata and rresp hold stable until rready=1; then return to R_IDLE.
- Read and write FSMs are fully independent; both may be active in the same cycle.
- Read/write collision: an AR handshake on the same edge as a write commit to the same index returns the pre-write value. A later read returns the new value.
- Handshakes never depend combinationally on valid: ready is registered state only.

Optional Feature:
- Macro: AXIL_SLAVE_ID_REG_EN.
- Defined:
  - Index 0 is read-only and always reads ID_VALUE with OKAY.
  - Writes to index 0 are discarded and answered with SLVERR.
  - Reset leaves index 0 reading ID_VALUE.
- Undefined: index 0 is an ordinary read/write register; ID_VALUE is unused.

Test Plan:
- Reset, then write awaddr=0x08, wdata=0x00000031, wstrb=0xF, then read 0x08 -> bvalid 1 cycle after handshake with bresp=0; read returns rdata=0x00000031, rresp=0, rvalid 1 cycle after AR handshake.
- W handshake 3 cycles before AW (addr 0x10, data 0xDEADBEEF), bready held 0 for 4 cycles -> wready drops after W; bvalid stays high with bresp=0 until bready; read 0x10 returns 0xDEADBEEF.
- Write 0xFFFFFFFF to 0x04, then write 0x12345678 with wstrb=0x5 -> read 0x04 returns 0xFF34FF78.
- Write and read at 0x40 (index 16, NUM_REGS=16) -> bresp=2 and register contents unchanged; rresp=2 with rdata=0.
- AR to 0x0C on the same edge the write of 0x55 to 0x0C commits (old value 0) -> rdata=0; next read returns 0x55. rready held 0 for 5 cycles keeps rvalid/rdata stable.
- Assert s_axi_areset while bvalid=1 and rvalid=1 -> both drop immediately; awready/wready/arready=1; all registers read 0 (ID_VALUE at 0x00 with AXIL_SLAVE_ID_REG_EN; a write there returns bresp=2).

Source files
------------

// File: rtl/axil_slave_regs.sv
// -----------------------------------------------------------------------------
// axil_slave_regs
//
// AXI4-Lite register bank: NUM_REGS word-wide read/write registers behind a
// single AXI4-Lite responder port. Write address and write data are accepted
// independently, in either order. The write commits on the edge where the
// second of the two is captured. Reads return registered data one cycle after
// the AR handshake. Accesses to a word index >= NUM_REGS are answered with
// SLVERR: such writes change nothing, and such reads return zero.
//
// Optional feature (compile-time macro AXIL_SLAVE_ID_REG_EN):
//   When defined, word index 0 is a read-only ID register that always returns
//   ID_VALUE with OKAY. Writes to index 0 are discarded and answered with
//   SLVERR. When undefined, index 0 is an ordinary register and ID_VALUE is
//   unused.
//
// Parameters:
//   DATA_WIDTH  data bus width (must be 32)
//   ADDR_WIDTH  byte address width
//   RESP_WIDTH  response field width (OKAY=0, SLVERR=2, zero-extended)
//   NUM_REGS    number of word registers, 2 .. 2**(ADDR_WIDTH-2)
//   ID_VALUE    constant returned by the optional ID register
//
// Ports:
//   s_axi_aclk      in   clock, rising edge
//   s_axi_areset    in   asynchronous, active-high reset
//   s_axi_aw*       write address channel (awaddr, awvalid / awready)
//   s_axi_w*        write data channel    (wdata, wstrb, wvalid / wready)
//   s_axi_b*        write response        (bresp, bvalid / bready)
//   s_axi_ar*       read address channel  (araddr, arvalid / arready)
//   s_axi_r*        read data channel     (rdata, rresp, rvalid / rready)
// -----------------------------------------------------------------------------
module axil_slave_regs #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 8,
  parameter int          RESP_WIDTH = 3,
  parameter int          NUM_REGS   = 16,
  parameter logic [31:0] ID_VALUE   = 32'hA5A5_0001
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_areset,
  // write address
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  // write data
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  // write response
  output logic [RESP_WIDTH-1:0]   s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  // read address
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  // read data
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [RESP_WIDTH-1:0]   s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int IDX_WIDTH  = ADDR_WIDTH - 2;
  localparam int SEL_WIDTH  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = '0;
  localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = RESP_WIDTH'(2);

  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_RESP = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  // ---------------------------------------------------------------------------
  // Address decode helpers
  // ---------------------------------------------------------------------------
  function automatic logic idx_in_range(input logic [IDX_WIDTH-1:0] idx);
    return int'(idx) < NUM_REGS;
  endfunction

  // A write is accepted only for in-range indices that are not read-only.
  function automatic logic idx_writable(input logic [IDX_WIDTH-1:0] idx);
`ifdef AXIL_SLAVE_ID_REG_EN
    return idx_in_range(idx) && (idx != '0);
`else
    return idx_in_range(idx);
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // Register storage
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // ---------------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------------
  logic [0:0]            w_state;
  logic                  aw_have;    // address captured, waiting for data
  logic                  w_have;     // data captured, waiting for address
  logic [IDX_WIDTH-1:0]  aw_idx_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_WIDTH-1:0] w_strb_q;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  wr_commit;
  logic [IDX_WIDTH-1:0]  wr_idx;
  logic [SEL_WIDTH-1:0]  wr_sel;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_WIDTH-1:0] wr_strb;
  logic                  wr_ok;

  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs  = s_axi_wvalid  & s_axi_wready;

  // The write completes on the edge where the later of AW/W arrives; each
  // side is taken either from this cycle's handshake or from its latch.
  // Both readies are 0 outside W_IDLE, so no commit can occur there.
  assign wr_commit = (aw_hs | aw_have) & (w_hs | w_have);
  assign wr_idx    = aw_hs ? s_axi_awaddr[ADDR_WIDTH-1:2] : aw_idx_q;
  assign wr_data   = w_hs  ? s_axi_wdata : w_data_q;
  assign wr_strb   = w_hs  ? s_axi_wstrb : w_strb_q;
  assign wr_sel    = wr_idx[SEL_WIDTH-1:0];
  assign wr_ok     = idx_writable(wr_idx);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      w_state       <= W_IDLE;
      s_axi_awready <= 1'b1;
      s_axi_wready  <= 1'b1;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      aw_have       <= 1'b0;
      w_have        <= 1'b0;
      aw_idx_q      <= '0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (wr_commit) begin
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            aw_have       <= 1'b0;
            w_have        <= 1'b0;
            s_axi_bvalid  <= 1'b1;
            s_axi_bresp   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            w_state       <= W_RESP;
          end else begin
            if (aw_hs) begin
              aw_have       <= 1'b1;
              s_axi_awready <= 1'b0;
              aw_idx_q      <= s_axi_awaddr[ADDR_WIDTH-1:2];
            end
            if (w_hs) begin
              w_have       <= 1'b1;
              s_axi_wready <= 1'b0;
              w_data_q     <= s_axi_wdata;
              w_strb_q     <= s_axi_wstrb;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // NOTE: the register array is reset explicitly because its contents are
  // architecturally visible after reset, so it cannot map onto reset-less RAM.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_commit && wr_ok) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (wr_strb[b]) begin
          regs[wr_sel][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------------
  logic [0:0]            r_state;
  logic                  ar_hs;
  logic [IDX_WIDTH-1:0]  rd_idx;
  logic [SEL_WIDTH-1:0]  rd_sel;
  logic [DATA_WIDTH-1:0] rd_value;
  logic [RESP_WIDTH-1:0] rd_resp;

  assign ar_hs  = s_axi_arvalid & s_axi_arready;
  assign rd_idx = s_axi_araddr[ADDR_WIDTH-1:2];
  assign rd_sel = rd_idx[SEL_WIDTH-1:0];

  // Reads sample the array before any same-edge write lands, so a colliding
  // read returns the pre-write value.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    rd_value = '0;
    rd_resp  = RESP_SLVERR;
    if (idx_in_range(rd_idx)) begin
      rd_resp  = RESP_OKAY;
      rd_value = regs[rd_sel];
`ifdef AXIL_SLAVE_ID_REG_EN
      if (rd_idx == '0) begin
        rd_value = ID_VALUE;
      end
`endif
    end
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b1;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            s_axi_rdata   <= rd_value;
            s_axi_rresp   <= rd_resp;
            s_axi_rvalid  <= 1'b1;
            s_axi_arready <= 1'b0;
            r_state       <= R_DATA;
          end
        end
        R_DATA: begin
          if (s_axi_rready) begin
            s_axi_rvalid  <= 1'b0;
            s_axi_arready <= 1'b1;
            r_state       <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Byte-offset address bits carry no meaning for word registers.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

`ifndef AXIL_SLAVE_ID_REG_EN
  logic unused_id_value;
  assign unused_id_value = ^ID_VALUE;
`endif

endmodule

// File: tb/tb_axil_slave_regs.sv
// -----------------------------------------------------------------------------
// tb_axil_slave_regs
//
// Directed test of axil_slave_regs with its default parameters (8-bit byte
// address, 16 registers). Each scenario task drives its stimulus and compares
// the outputs against hand-computed values. Expectations for index 0 follow
// the AXIL_SLAVE_ID_REG_EN macro.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axil_slave_regs;

  localparam logic [31:0] ID_VALUE = 32'hA5A5_0001;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_axi_awaddr;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [2:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [7:0]  s_axi_araddr;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [2:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axil_slave_regs dut (
    .s_axi_aclk    (clk),
    .s_axi_areset  (rst),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready)
  );

  // ---------------------------------------------------------------------------
  // Bus drivers. Called at posedge+1 with the DUT idle; they return at
  // posedge+1 after the final handshake. lat_ok reports whether the response
  // valid was already high right after the completing address/data edge.
  // ---------------------------------------------------------------------------
  task automatic do_write(input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [2:0] resp,
                          output logic lat_ok);
    bit aw_done = 0;
    bit w_done  = 0;
    bit aw_now, w_now, bv, b_done;
    int n = 0;
    s_axi_awaddr = a; s_axi_awvalid = 1'b1;
    s_axi_wdata  = d; s_axi_wstrb   = s; s_axi_wvalid = 1'b1;
    s_axi_bready = 1'b0;
    resp = 3'bxxx; lat_ok = 1'b0;
    while (!(aw_done && w_done) && n < 20) begin
      aw_now = s_axi_awvalid && s_axi_awready;
      w_now  = s_axi_wvalid && s_axi_wready;
      @(posedge clk); #1; n++;
      if (aw_now) begin aw_done = 1; s_axi_awvalid = 1'b0; end
      if (w_now)  begin w_done  = 1; s_axi_wvalid  = 1'b0; end
    end
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    checks++;
    if (!(aw_done && w_done)) begin
      errors++;
      $display("FAIL write_handshake_timeout: addr %h aw=%0b w=%0b, required both", a, aw_done, w_done);
      return;
    end
    lat_ok = s_axi_bvalid;
    resp   = s_axi_bresp;
    s_axi_bready = 1'b1;
    b_done = 0; n = 0;
    while (!b_done && n < 20) begin
      bv = s_axi_bvalid;
      @(posedge clk); #1; n++;
      if (bv) b_done = 1;
    end
    s_axi_bready = 1'b0;
    checks++;
    if (!b_done) begin
      errors++;
      $display("FAIL write_resp_timeout: addr %h bvalid never seen, required 1", a);
    end
  endtask

  task automatic do_read(input logic [7:0] a, output logic [31:0] d,
                         output logic [2:0] resp, output logic lat_ok);
    bit ar_done = 0;
    bit ar_now, rv, r_done;
    int n = 0;
    s_axi_araddr = a; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
    d = 'x; resp = 3'bxxx; lat_ok = 1'b0;
    while (!ar_done && n < 20) begin
      ar_now = s_axi_arvalid && s_axi_arready;
      @(posedge clk); #1; n++;
      if (ar_now) begin ar_done = 1; s_axi_arvalid = 1'b0; end
    end
    s_axi_arvalid = 1'b0;
    checks++;
    if (!ar_done) begin
      errors++;
      $display("FAIL read_handshake_timeout: addr %h arready never seen, required 1", a);
      return;
    end
    lat_ok = s_axi_rvalid;
    r_done = 0; n = 0;
    while (!s_axi_rvalid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    d = s_axi_rdata; resp = s_axi_rresp;
    s_axi_rready = 1'b1;
    n = 0;
    while (!r_done && n < 20) begin
      rv = s_axi_rvalid;
      @(posedge clk); #1; n++;
      if (rv) r_done = 1;
    end
    s_axi_rready = 1'b0;
    checks++;
    if (!r_done) begin
      errors++;
      $display("FAIL read_data_timeout: addr %h rvalid never seen, required 1", a);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = '0;
    s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
      errors++;
      $display("FAIL reset_readies: aw/w/ar=%b, required 111", {s_axi_awready, s_axi_wready, s_axi_arready});
    end
    checks++;
    if ({s_axi_bvalid, s_axi_rvalid} !== 2'b00) begin
      errors++;
      $display("FAIL reset_valids: b/r=%b, required 00", {s_axi_bvalid, s_axi_rvalid});
    end
    checks++;
    if (s_axi_bresp !== 3'd0 || s_axi_rresp !== 3'd0 || s_axi_rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: bresp=%0d rresp=%0d rdata=%h, required 0 0 00000000", s_axi_bresp, s_axi_rresp, s_axi_rdata);
    end
  endtask

  task automatic test_basic();
    logic [2:0] resp; logic [31:0] d; logic lat;
    do_write(8'h08, 32'h0000_0031, 4'hF, resp, lat);
    checks++;
    if (lat !== 1'b1 || resp !== 3'd0) begin
      errors++;
      $display("FAIL basic_write: bvalid_at_1=%b bresp=%0d, required 1 0", lat, resp);
    end
    do_read(8'h08, d, resp, lat);
    checks++;
    if (lat !== 1'b1 || resp !== 3'd0 || d !== 32'h0000_0031) begin
      errors++;
      $display("FAIL basic_read: rvalid_at_1=%b rresp=%0d rdata=%h, required 1 0 00000031", lat, resp, d);
    end
  endtask

  task automatic test_w_before_aw();
    logic [2:0] resp; logic [31:0] d; logic lat;
    s_axi_wdata = 32'hDEAD_BEEF; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    s_axi_bready = 1'b0;
    @(posedge clk); #1; s_axi_wvalid = 1'b0;
    checks++;
    if (s_axi_wready !== 1'b0 || s_axi_awready !== 1'b1) begin
      errors++;
      $display("FAIL w_first_readies: wready=%b awready=%b, required 0 1", s_axi_wready, s_axi_awready);
    end
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (s_axi_bvalid !== 1'b0) begin
      errors++;
      $display("FAIL w_first_no_early_resp: bvalid=%b, required 0", s_axi_bvalid);
    end
    s_axi_awaddr = 8'h10; s_axi_awvalid = 1'b1;
    @(posedge clk); #1; s_axi_awvalid = 1'b0;
    checks++;
    if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== 3'd0 || s_axi_awready !== 1'b0) begin
      errors++;
      $display("FAIL w_first_commit: bvalid=%b bresp=%0d awready=%b, required 1 0 0", s_axi_bvalid, s_axi_bresp, s_axi_awready);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== 3'd0) begin
        errors++;
        $display("FAIL w_first_hold_%0d: bvalid=%b bresp=%0d, required 1 0", i, s_axi_bvalid, s_axi_bresp);
      end
    end
    s_axi_bready = 1'b1;
    @(posedge clk); #1; s_axi_bready = 1'b0;
    checks++;
    if (s_axi_bvalid !== 1'b0 || s_axi_awready !== 1'b1 || s_axi_wready !== 1'b1) begin
      errors++;
      $display("FAIL w_first_release: bvalid=%b awready=%b wready=%b, required 0 1 1", s_axi_bvalid, s_axi_awready, s_axi_wready);
    end
    do_read(8'h10, d, resp, lat);
    checks++;
    if (resp !== 3'd0 || d !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL w_first_readback: rresp=%0d rdata=%h, required 0 deadbeef", resp, d);
    end
  endtask

  task automatic test_strobes();
    logic [2:0] resp; logic [31:0] d; logic lat;
    do_write(8'h04, 32'hFFFF_FFFF, 4'hF, resp, lat);
    do_write(8'h04, 32'h1234_5678, 4'h5, resp, lat);
    do_read(8'h04, d, resp, lat);
    checks++;
    if (d !== 32'hFF34_FF78) begin
      errors++;
      $display("FAIL strobe_partial: rdata=%h, required ff34ff78", d);
    end
    do_write(8'h04, 32'h0000_0000, 4'h0, resp, lat);
    checks++;
    if (resp !== 3'd0) begin
      errors++;
      $display("FAIL strobe_zero_resp: bresp=%0d, required 0", resp);
    end
    do_read(8'h04, d, resp, lat);
    checks++;
    if (d !== 32'hFF34_FF78) begin
      errors++;
      $display("FAIL strobe_zero_data: rdata=%h, required ff34ff78", d);
    end
  endtask

  task automatic test_decode();
    logic [2:0] resp; logic [31:0] d; logic lat;
    // Index 16 is one past the last register.
    do_write(8'h40, 32'h0000_ABCD, 4'hF, resp, lat);
    checks++;
    if (resp !== 3'd2) begin
      errors++;
      $display("FAIL decode_write_slverr: bresp=%0d, required 2", resp);
    end
    do_read(8'h40, d, resp, lat);
    checks++;
    if (resp !== 3'd2 || d !== 32'd0) begin
      errors++;
      $display("FAIL decode_read_slverr: rresp=%0d rdata=%h, required 2 00000000", resp, d);
    end
    // The failed write must not alias onto index 0.
    do_read(8'h00, d, resp, lat);
    checks++;
`ifdef AXIL_SLAVE_ID_REG_EN
    if (resp !== 3'd0 || d !== ID_VALUE) begin
      errors++;
      $display("FAIL decode_no_alias: rresp=%0d rdata=%h, required 0 %h", resp, d, ID_VALUE);
    end
`else
    if (resp !== 3'd0 || d !== 32'd0) begin
      errors++;
      $display("FAIL decode_no_alias: rresp=%0d rdata=%h, required 0 00000000", resp, d);
    end
`endif
    // Last valid index, addressed with nonzero byte offset bits.
    do_write(8'h3F, 32'hCAFE_0015, 4'hF, resp, lat);
    checks++;
    if (resp !== 3'd0) begin
      errors++;
      $display("FAIL decode_last_write: bresp=%0d, required 0", resp);
    end
    do_read(8'h3C, d, resp, lat);
    checks++;
    if (resp !== 3'd0 || d !== 32'hCAFE_0015) begin
      errors++;
      $display("FAIL decode_last_read: rresp=%0d rdata=%h, required 0 cafe0015", resp, d);
    end
  endtask

  task automatic test_collision();
    logic [2:0] resp; logic [31:0] d; logic lat;
    s_axi_awaddr = 8'h0C; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'h0000_0055; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    s_axi_araddr = 8'h0C; s_axi_arvalid = 1'b1;
    s_axi_bready = 1'b1; s_axi_rready = 1'b0;
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    checks++;
    if (s_axi_bvalid !== 1'b1 || s_axi_rvalid !== 1'b1 || s_axi_rdata !== 32'd0) begin
      errors++;
      $display("FAIL collision_old_value: bvalid=%b rvalid=%b rdata=%h, required 1 1 00000000", s_axi_bvalid, s_axi_rvalid, s_axi_rdata);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== 32'd0 || s_axi_rresp !== 3'd0) begin
        errors++;
        $display("FAIL collision_hold_%0d: rvalid=%b rdata=%h rresp=%0d, required 1 00000000 0", i, s_axi_rvalid, s_axi_rdata, s_axi_rresp);
      end
    end
    s_axi_bready = 1'b0;
    s_axi_rready = 1'b1;
    @(posedge clk); #1; s_axi_rready = 1'b0;
    checks++;
    if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b1) begin
      errors++;
      $display("FAIL collision_release: rvalid=%b arready=%b, required 0 1", s_axi_rvalid, s_axi_arready);
    end
    do_read(8'h0C, d, resp, lat);
    checks++;
    if (d !== 32'h0000_0055) begin
      errors++;
      $display("FAIL collision_new_value: rdata=%h, required 00000055", d);
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] resp; logic [31:0] d; logic lat;
    logic [7:0] addrs [5] = '{8'h04, 8'h08, 8'h0C, 8'h10, 8'h3C};
    s_axi_awaddr = 8'h20; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'h0000_0077; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    s_axi_araddr = 8'h08; s_axi_arvalid = 1'b1;
    s_axi_bready = 1'b0; s_axi_rready = 1'b0;
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    checks++;
    if (s_axi_bvalid !== 1'b1 || s_axi_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL midreset_setup: bvalid=%b rvalid=%b, required 1 1", s_axi_bvalid, s_axi_rvalid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({s_axi_bvalid, s_axi_rvalid} !== 2'b00 ||
        {s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
      errors++;
      $display("FAIL midreset_immediate: b/r valid=%b aw/w/ar ready=%b, required 00 111", {s_axi_bvalid, s_axi_rvalid}, {s_axi_awready, s_axi_wready, s_axi_arready});
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    do_read(8'h20, d, resp, lat);
    checks++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL midreset_inflight_cleared: rdata=%h, required 00000000", d);
    end
    foreach (addrs[i]) begin
      do_read(addrs[i], d, resp, lat);
      checks++;
      if (d !== 32'd0 || resp !== 3'd0) begin
        errors++;
        $display("FAIL midreset_clear_%h: rdata=%h rresp=%0d, required 00000000 0", addrs[i], d, resp);
      end
    end
  endtask

  task automatic test_index0();
    logic [2:0] resp; logic [31:0] d; logic lat;
    do_read(8'h00, d, resp, lat);
    checks++;
`ifdef AXIL_SLAVE_ID_REG_EN
    if (d !== ID_VALUE || resp !== 3'd0) begin
      errors++;
      $display("FAIL index0_after_reset: rdata=%h rresp=%0d, required %h 0", d, resp, ID_VALUE);
    end
`else
    if (d !== 32'd0 || resp !== 3'd0) begin
      errors++;
      $display("FAIL index0_after_reset: rdata=%h rresp=%0d, required 00000000 0", d, resp);
    end
`endif
    do_write(8'h00, 32'h1111_2222, 4'hF, resp, lat);
    checks++;
`ifdef AXIL_SLAVE_ID_REG_EN
    if (resp !== 3'd2) begin
      errors++;
      $display("FAIL index0_write_resp: bresp=%0d, required 2", resp);
    end
`else
    if (resp !== 3'd0) begin
      errors++;
      $display("FAIL index0_write_resp: bresp=%0d, required 0", resp);
    end
`endif
    do_read(8'h00, d, resp, lat);
    checks++;
`ifdef AXIL_SLAVE_ID_REG_EN
    if (d !== ID_VALUE) begin
      errors++;
      $display("FAIL index0_readback: rdata=%h, required %h", d, ID_VALUE);
    end
`else
    if (d !== 32'h1111_2222) begin
      errors++;
      $display("FAIL index0_readback: rdata=%h, required 11112222", d);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_w_before_aw();
    test_strobes();
    test_decode();
    test_collision();
    test_reset_mid();
    test_index0();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time limit in case a handshake loop is ever left unbounded.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded 200000 ns, required completion");
    $fatal(1, "timeout");
  end

endmodule
